// File: rtl/score_counter.sv
// -----------------------------------------------------------------------------
// score_counter
//
// Game-score accumulator feeding the seven-segment display path.
//
// Gameplay logic sends one-cycle hit/miss pulses. The block keeps three things:
//   - a consecutive-hit streak, which saturates at 255
//   - a combo multiplier derived from the streak
//   - a 4-digit BCD score, with one nibble per hex_decoder
//
// Each accepted hit queues `mult` points into a pending register. A two-state
// FSM then drains the pending register into the score at one point per clock.
// Because of this, the BCD path only ever needs a +1 incrementer with digit
// carries. It never needs a full multi-digit BCD adder.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   resetn  in   1   asynchronous active-low reset
//   clear   in   1   synchronous clear of all game state (beats miss and hit)
//   hit     in   1   one-cycle pulse, note played correctly
//   miss    in   1   one-cycle pulse, note missed (beats a same-cycle hit)
//   score   out  16  BCD score {thousands, hundreds, tens, ones}
//   streak  out  8   consecutive-hit count, binary, saturating at 255
//   mult    out  3   combo multiplier 1..4 (combinational from streak)
//   busy    out  1   high while pending points are still being added
//
// Parameters:
//   MAX_PEND  saturation value of the 6-bit pending-points register
// -----------------------------------------------------------------------------
module score_counter #(
    parameter int unsigned MAX_PEND = 63
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        hit,
    input  logic        miss,
    output logic [15:0] score,
    output logic [7:0]  streak,
    output logic [2:0]  mult,
    output logic        busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [6:0] MAX_PEND_W = 7'(MAX_PEND);
    localparam logic [5:0] MAX_PEND_S = 6'(MAX_PEND);
    localparam logic [7:0] STREAK_MAX = 8'd255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q,  state_d;
    logic [15:0] score_q,  score_d;
    logic [7:0]  streak_q, streak_d;
    logic [5:0]  pend_q,   pend_d;

    // -------------------------------------------------------------------------
    // Input qualification
    // A hit only counts when neither clear nor miss is present in the same cycle.
    // -------------------------------------------------------------------------
    logic hit_only;
    assign hit_only = hit & ~miss & ~clear;

    // -------------------------------------------------------------------------
    // Combo multiplier
    // streak[7:3] is streak/8. Values 0, 1 and 2 map to x1, x2 and x3.
    // Anything from 24 upward gives x4.
    // -------------------------------------------------------------------------
    logic [2:0] mult_w;

    always_comb begin
        mult_w = 3'd4;
        case (streak_q[7:3])
            5'd0:    mult_w = 3'd1;
            5'd1:    mult_w = 3'd2;
            5'd2:    mult_w = 3'd3;
            default: mult_w = 3'd4;
        endcase
    end

    // Points contributed this cycle. The multiplier is taken from the streak
    // value before this hit increments it.
    logic [2:0] add_amt;
    assign add_amt = hit_only ? mult_w : 3'd0;

    // -------------------------------------------------------------------------
    // Streak register next value
    // -------------------------------------------------------------------------
    always_comb begin
        streak_d = streak_q;
        if (clear || miss) begin
            streak_d = 8'd0;
        end else if (hit && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // BCD +1 incrementer
    // A digit rolls over only when every digit below it is 9.
    // carry[4] set means the score is 9999. In that case the score holds
    // instead of wrapping to 0000.
    // -------------------------------------------------------------------------
    logic [4:0]  bcd_carry;
    logic [15:0] score_inc;
    logic [15:0] score_step;

    assign bcd_carry[0] = 1'b1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd_digit
        logic [3:0] digit;
        logic       is_nine;

        assign digit   = score_q[gi*4 +: 4];
        assign is_nine = (digit == 4'd9);

        assign score_inc[gi*4 +: 4] = !bcd_carry[gi] ? digit :
                                      (is_nine ? 4'd0 : digit + 4'd1);
        assign bcd_carry[gi+1] = bcd_carry[gi] & is_nine;
    end

    assign score_step = bcd_carry[4] ? score_q : score_inc;

    // -------------------------------------------------------------------------
    // Pending arithmetic for the ADD state
    // In ADD, pend_q is always >= 1, so subtracting 1 cannot underflow.
    // The sum can reach 62 + 4, which is why it is computed at 7 bits and
    // then clamped.
    // -------------------------------------------------------------------------
    logic [6:0] pend_sum;
    logic [5:0] pend_sat;

    assign pend_sum = {1'b0, pend_q} - 7'd1 + {4'd0, add_amt};
    assign pend_sat = (pend_sum > MAX_PEND_W) ? MAX_PEND_S : pend_sum[5:0];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hit_only) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (pend_sat == 6'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath logic
    // In IDLE the score is held and a hit loads pending directly.
    // In ADD the score takes one BCD step per cycle while pending drains.
    // -------------------------------------------------------------------------
    always_comb begin
        score_d = score_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                pend_d = {3'd0, add_amt};
            end
            ST_ADD: begin
                score_d = score_step;
                pend_d  = pend_sat;
            end
            default: begin
                pend_d = 6'd0;
            end
        endcase
        if (clear) begin
            score_d = 16'h0000;
            pend_d  = 6'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q  <= 16'h0000;
            streak_q <= 8'd0;
            pend_q   <= 6'd0;
        end else begin
            score_q  <= score_d;
            streak_q <= streak_d;
            pend_q   <= pend_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // busy is a direct decode of the state flop, so it carries no
    // combinational input path.
    // -------------------------------------------------------------------------
    assign score  = score_q;
    assign streak = streak_q;
    assign mult   = mult_w;
    assign busy   = (state_q == ST_ADD);

endmodule
